// File: rtl/sha_nonce_scheduler.sv
// sha_nonce_scheduler: takes one mining job, splits the nonce space across
// NUM_CORES sha256_double cores, starts them together and reports the first
// winning nonce (lowest core index wins ties) or not-found on timeout.
//
// Handshakes (both strict valid/ready): a transfer happens on a rising clk
// edge where valid && ready are both high. job_ready is high only in IDLE.
// res_valid rises the cycle after a result is detected, and res_valid and all
// res_* fields then hold steady until the edge where res_ready is seen high.
module sha_nonce_scheduler #(
  parameter int          NUM_CORES  = 4,             // 1..16
  parameter logic [31:0] STRIDE     = 32'h4000_0000,
  parameter int          RST_CYCLES = 2              // 1..255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [95:0]               job_data,
  input  logic [255:0]              job_state,
  input  logic [255:0]              job_target,
  input  logic [31:0]               job_nonce_base,
  input  logic [31:0]               job_position,
  input  logic [31:0]               job_timeout,
  input  logic                      abort,
  output logic [NUM_CORES-1:0]      core_rst,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [95:0]               core_data,
  output logic [255:0]              core_state,
  output logic [255:0]              core_target,
  output logic [31:0]               core_position,
  output logic [32*NUM_CORES-1:0]   core_nonce_base,
  input  logic [NUM_CORES-1:0]      core_done,
  input  logic [32*NUM_CORES-1:0]   core_nonce,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_found,
  output logic [31:0]               res_nonce,
  output logic [3:0]                res_core,
  output logic                      busy,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                rst_cnt_q, rst_cnt_d;
  logic [31:0]               tmo_cnt_q, tmo_cnt_d;
  logic [31:0]               timeout_q;
  logic [95:0]               data_q;
  logic [255:0]              midstate_q;
  logic [255:0]              target_q;
  logic [31:0]               position_q;
  logic [32*NUM_CORES-1:0]   base_q;
  logic                      res_found_q, res_found_d;
  logic [31:0]               res_nonce_q, res_nonce_d;
  logic [3:0]                res_core_q, res_core_d;
  logic                      accept;

  logic                      win_any;
  logic [3:0]                win_idx;
  logic [31:0]               win_nonce;

  // Lowest-index done core wins; scanning downward lets the lowest overwrite.
  always_comb begin
    win_any   = 1'b0;
    win_idx   = 4'd0;
    win_nonce = 32'd0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_done[i]) begin
        win_any   = 1'b1;
        win_idx   = 4'(i);
        win_nonce = core_nonce[i*32 +: 32];
      end
    end
  end

  // Next-state logic; abort outranks core_done, core_done outranks timeout.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    res_found_d = res_found_q;
    res_nonce_d = res_nonce_q;
    res_core_d  = res_core_q;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          accept    = 1'b1;
          rst_cnt_d = 8'(RST_CYCLES - 1);
          state_d   = S_RESET;
        end
      end
      S_RESET: begin
        if (abort)                state_d = S_IDLE;
        else if (rst_cnt_q == 8'd0) state_d = S_START;
        else                      rst_cnt_d = rst_cnt_q - 8'd1;
      end
      S_START: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = timeout_q;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (win_any) begin
          res_found_d = 1'b1;
          res_nonce_d = win_nonce;
          res_core_d  = win_idx;
          state_d     = S_REPORT;
        end else if (timeout_q != 32'd0 && tmo_cnt_q == 32'd1) begin
          res_found_d = 1'b0;
          res_nonce_d = 32'd0;
          res_core_d  = 4'd0;
          state_d     = S_REPORT;
        end else if (timeout_q != 32'd0) begin
          tmo_cnt_d = tmo_cnt_q - 32'd1;
        end
      end
      S_REPORT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= 8'd0;
      tmo_cnt_q   <= 32'd0;
      res_found_q <= 1'b0;
      res_nonce_q <= 32'd0;
      res_core_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      res_found_q <= res_found_d;
      res_nonce_q <= res_nonce_d;
      res_core_q  <= res_core_d;
    end
  end

  // Job field capture and per-core nonce slice bases (wrap mod 2^32).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout_q  <= 32'd0;
      data_q     <= 96'd0;
      midstate_q <= 256'd0;
      target_q   <= 256'd0;
      position_q <= 32'd0;
      base_q     <= '0;
    end else if (accept) begin
      timeout_q  <= job_timeout;
      data_q     <= job_data;
      midstate_q <= job_state;
      target_q   <= job_target;
      position_q <= job_position;
      for (int i = 0; i < NUM_CORES; i++) begin
        base_q[i*32 +: 32] <= job_nonce_base + 32'(i) * STRIDE;
      end
    end
  end

  assign job_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign core_rst        = (state_q == S_IDLE || state_q == S_RESET) ? '1 : '0;
  assign core_start      = (state_q == S_START) ? '1 : '0;
  assign core_data       = data_q;
  assign core_state      = midstate_q;
  assign core_target     = target_q;
  assign core_position   = position_q;
  assign core_nonce_base = base_q;
  assign res_valid       = (state_q == S_REPORT);
  assign res_found       = res_found_q;
  assign res_nonce       = res_nonce_q;
  assign res_core        = res_core_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench for sha_nonce_scheduler (NUM_CORES=4, STRIDE=0x4000_0000,
// RST_CYCLES=2). Inputs are driven 1 time unit after each rising edge and
// outputs are sampled at that same point, away from the active edge.
module tb_sha_nonce_scheduler;

  logic          clk = 1'b0;
  logic          rstn;
  logic          job_valid;
  logic          job_ready;
  logic [95:0]   job_data;
  logic [255:0]  job_state;
  logic [255:0]  job_target;
  logic [31:0]   job_nonce_base;
  logic [31:0]   job_position;
  logic [31:0]   job_timeout;
  logic          abort;
  logic [3:0]    core_rst;
  logic [3:0]    core_start;
  logic [95:0]   core_data;
  logic [255:0]  core_state;
  logic [255:0]  core_target;
  logic [31:0]   core_position;
  logic [127:0]  core_nonce_base;
  logic [3:0]    core_done;
  logic [127:0]  core_nonce;
  logic          res_valid;
  logic          res_ready;
  logic          res_found;
  logic [31:0]   res_nonce;
  logic [3:0]    res_core;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  sha_nonce_scheduler #(
    .NUM_CORES(4), .STRIDE(32'h4000_0000), .RST_CYCLES(2)
  ) dut (
    .clk(clk), .rstn(rstn),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_data(job_data), .job_state(job_state), .job_target(job_target),
    .job_nonce_base(job_nonce_base), .job_position(job_position),
    .job_timeout(job_timeout), .abort(abort),
    .core_rst(core_rst), .core_start(core_start),
    .core_data(core_data), .core_state(core_state),
    .core_target(core_target), .core_position(core_position),
    .core_nonce_base(core_nonce_base),
    .core_done(core_done), .core_nonce(core_nonce),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_found(res_found), .res_nonce(res_nonce), .res_core(res_core),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Offer a job; returns in the first RESET cycle (T+1).
  task automatic accept_job(input logic [31:0] base, input logic [31:0] tmo);
    job_data       = 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4;
    job_state      = {8{32'h6A09E667}};
    job_target     = {32'h0000FFFF, 224'd0};
    job_position   = 32'h0000_004C;
    job_nonce_base = base;
    job_timeout    = tmo;
    job_valid      = 1'b1;
    n_cmp++; if (job_ready !== 1'b1) begin n_err++; $display("FAIL accept_ready got=%b exp=1", job_ready); end
    tick();
    job_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", busy); end
    n_cmp++; if (core_rst !== 4'hF) begin n_err++; $display("FAIL reset_core_rst got=%h exp=f", core_rst); end
    n_cmp++; if (core_start !== 4'h0) begin n_err++; $display("FAIL reset_core_start got=%h exp=0", core_start); end
  endtask

  // Offer a job and advance to the START cycle (T+3).
  task automatic start_job(input logic [31:0] base, input logic [31:0] tmo);
    accept_job(base, tmo);
    tick();
    n_cmp++; if (core_start !== 4'h0) begin n_err++; $display("FAIL t2_core_start got=%h exp=0", core_start); end
    tick();
    n_cmp++; if (core_start !== 4'hF) begin n_err++; $display("FAIL t3_core_start got=%h exp=f", core_start); end
    n_cmp++; if (core_rst !== 4'h0) begin n_err++; $display("FAIL t3_core_rst got=%h exp=0", core_rst); end
  endtask

  task automatic test_reset();
    rstn = 1'b0; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    core_done = 4'h0; core_nonce = '0;
    job_data = '0; job_state = '0; job_target = '0;
    job_nonce_base = '0; job_position = '0; job_timeout = '0;
    tick_n(3);
    n_cmp++; if (core_rst !== 4'hF) begin n_err++; $display("FAIL rst_core_rst got=%h exp=f", core_rst); end
    n_cmp++; if (busy !== 1'b0 || job_ready !== 1'b1) begin n_err++; $display("FAIL rst_busy_ready got=%b%b exp=01", busy, job_ready); end
    n_cmp++; if (res_valid !== 1'b0 || res_found !== 1'b0) begin n_err++; $display("FAIL rst_res got=%b%b exp=00", res_valid, res_found); end
    n_cmp++; if (core_nonce_base !== 128'd0) begin n_err++; $display("FAIL rst_bases got=%h exp=0", core_nonce_base); end
    #2 rstn = 1'b1;
    tick();
  endtask

  task automatic test_found();
    start_job(32'h0000_0010, 32'd1000);
    n_cmp++; if (core_nonce_base !== {32'hC000_0010, 32'h8000_0010, 32'h4000_0010, 32'h0000_0010}) begin
      n_err++; $display("FAIL found_bases got=%h", core_nonce_base); end
    n_cmp++; if (core_data !== 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4 || core_position !== 32'h4C) begin
      n_err++; $display("FAIL found_broadcast got=%h/%h", core_data, core_position); end
    n_cmp++; if (core_state !== {8{32'h6A09E667}} || core_target !== {32'h0000FFFF, 224'd0}) begin
      n_err++; $display("FAIL found_state_target mismatched"); end
    tick_n(5);
    n_cmp++; if (core_start !== 4'h0 || res_valid !== 1'b0) begin n_err++; $display("FAIL found_run5 got=%h/%b exp=0/0", core_start, res_valid); end
    core_done = 4'b0100;
    core_nonce = {32'h0, 32'h8000_1234, 32'h0, 32'h0};
    tick();
    core_done = 4'h0;
    n_cmp++; if (res_valid !== 1'b1 || res_found !== 1'b1) begin n_err++; $display("FAIL found_res got=%b%b exp=11", res_valid, res_found); end
    n_cmp++; if (res_nonce !== 32'h8000_1234) begin n_err++; $display("FAIL found_nonce got=%h exp=80001234", res_nonce); end
    n_cmp++; if (res_core !== 4'd2) begin n_err++; $display("FAIL found_core got=%0d exp=2", res_core); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || job_ready !== 1'b1 || core_rst !== 4'hF) begin
      n_err++; $display("FAIL found_back_idle got=%b%b%h exp=01f", res_valid, job_ready, core_rst); end
  endtask

  task automatic test_priority_handshake();
    start_job(32'h1000_0000, 32'd1000);
    tick_n(2);
    core_done = 4'b1010;
    core_nonce = {32'h3333_0003, 32'h0, 32'h1111_0001, 32'h0};
    tick();
    // core_done during REPORT must not disturb the held result.
    core_done = 4'b0001;
    core_nonce = {32'h0, 32'h0, 32'h0, 32'h5555_5555};
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (res_valid !== 1'b1 || res_found !== 1'b1 || res_nonce !== 32'h1111_0001 || res_core !== 4'd1) begin
        n_err++; $display("FAIL prio_hold[%0d] got=%b%b %h %0d exp=11 11110001 1", k, res_valid, res_found, res_nonce, res_core);
      end
      tick();
    end
    core_done = 4'h0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if (job_ready !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL prio_release got=%b%b exp=10", job_ready, res_valid); end
  endtask

  task automatic test_timeout();
    start_job(32'h2000_0000, 32'd8);
    tick_n(8);
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL tmo_run8 got=%b%b exp=01", res_valid, busy); end
    tick();
    n_cmp++; if (res_valid !== 1'b1 || res_found !== 1'b0) begin n_err++; $display("FAIL tmo_res got=%b%b exp=10", res_valid, res_found); end
    n_cmp++; if (res_nonce !== 32'd0 || res_core !== 4'd0) begin n_err++; $display("FAIL tmo_nonce got=%h/%0d exp=0/0", res_nonce, res_core); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    // done on the last RUN cycle counts as found
    start_job(32'h2000_0000, 32'd8);
    tick_n(8);
    core_done = 4'b0001;
    core_nonce = {96'd0, 32'h0BAD_F00D};
    tick();
    core_done = 4'h0;
    n_cmp++; if (res_valid !== 1'b1 || res_found !== 1'b1 || res_nonce !== 32'h0BAD_F00D || res_core !== 4'd0) begin
      n_err++; $display("FAIL tmo_lastdone got=%b%b %h %0d exp=11 0badf00d 0", res_valid, res_found, res_nonce, res_core); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_wrap();
    accept_job(32'hF000_0000, 32'd4);
    n_cmp++; if (core_nonce_base !== {32'hB000_0000, 32'h7000_0000, 32'h3000_0000, 32'hF000_0000}) begin
      n_err++; $display("FAIL wrap_bases got=%h exp=b000000070000000300000000f0000000", core_nonce_base); end
    tick_n(7);
    n_cmp++; if (res_valid !== 1'b1 || res_found !== 1'b0) begin n_err++; $display("FAIL wrap_tmo got=%b%b exp=10", res_valid, res_found); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_abort();
    // abort in RESET
    accept_job(32'h0, 32'd100);
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++; if (job_ready !== 1'b1 || core_rst !== 4'hF || res_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_reset got=%b%h%b exp=1f0", job_ready, core_rst, res_valid); end
    // abort in START
    start_job(32'h0, 32'd100);
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++; if (job_ready !== 1'b1 || core_rst !== 4'hF || res_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_start got=%b%h%b exp=1f0", job_ready, core_rst, res_valid); end
    // abort in RUN together with core_done
    start_job(32'h0, 32'd100);
    tick_n(2);
    abort = 1'b1; core_done = 4'b0010; core_nonce = {64'd0, 32'h7777_7777, 32'd0};
    tick();
    abort = 1'b0; core_done = 4'h0;
    n_cmp++; if (job_ready !== 1'b1 || core_rst !== 4'hF || res_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_run got=%b%h%b exp=1f0", job_ready, core_rst, res_valid); end
    tick();
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_quiet got=%b%b exp=00", res_valid, busy); end
    // following job runs normally
    start_job(32'h0000_0100, 32'd5);
    tick_n(3);
    core_done = 4'b0001; core_nonce = {96'd0, 32'h0000_ABCD};
    tick();
    core_done = 4'h0;
    n_cmp++; if (res_valid !== 1'b1 || res_found !== 1'b1 || res_nonce !== 32'h0000_ABCD) begin
      n_err++; $display("FAIL abort_next got=%b%b %h exp=11 0000abcd", res_valid, res_found, res_nonce); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_unlimited_and_async_reset();
    start_job(32'h2000_0000, 32'd0);
    tick_n(50);
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL unlim_run50 got=%b%b exp=01", res_valid, busy); end
    core_done = 4'b1000; core_nonce = {32'hDEAD_BEEF, 96'd0};
    tick();
    core_done = 4'h0;
    n_cmp++; if (res_valid !== 1'b1 || res_nonce !== 32'hDEAD_BEEF || res_core !== 4'd3) begin
      n_err++; $display("FAIL unlim_res got=%b %h %0d exp=1 deadbeef 3", res_valid, res_nonce, res_core); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    // async reset mid-RUN, between clock edges
    start_job(32'h5555_0000, 32'd0);
    tick_n(3);
    #3 rstn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || job_ready !== 1'b1 || core_rst !== 4'hF || core_start !== 4'h0) begin
      n_err++; $display("FAIL arst_ctrl got=%b%b%h%h exp=1 1 f 0", busy, job_ready, core_rst, core_start); end
    n_cmp++; if (res_valid !== 1'b0 || res_found !== 1'b0 || res_nonce !== 32'd0 || res_core !== 4'd0) begin
      n_err++; $display("FAIL arst_res got=%b%b %h %0d exp=00 0 0", res_valid, res_found, res_nonce, res_core); end
    n_cmp++; if (core_nonce_base !== 128'd0 || core_data !== 96'd0 || core_position !== 32'd0) begin
      n_err++; $display("FAIL arst_regs got=%h %h %h exp=0", core_nonce_base, core_data, core_position); end
    #1 rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_found();
    test_priority_handshake();
    test_timeout();
    test_wrap();
    test_abort();
    test_unlimited_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha_nonce_scheduler.md
Name: sha_nonce_scheduler

Overview:
Job scheduler for a bank of NUM_CORES sha256_double cores. It accepts one mining job (header tail, midstate, target, nonce base, position, timeout) over a valid/ready handshake. It splits the 32-bit nonce space into per-core slices, resets and starts all cores together, and returns the first winning nonce, or not-found on timeout. It sits between the UART command front end and the hashing cores, replacing direct single-core control.

Parameters:
NUM_CORES, 4, number of sha256_double cores driven (1..16)
STRIDE, 32'h4000_0000, nonce offset between consecutive cores
RST_CYCLES, 2, cycles core_rst is held high before a start

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
job_valid  in  1  job offered
job_ready  out  1  high only in IDLE
job_data  in  96  12 header-tail bytes
job_state  in  256  SHA midstate
job_target  in  256  difficulty target
job_nonce_base  in  32  starting nonce
job_position  in  32  nonce position field
job_timeout  in  32  RUN-cycle budget; 0 = unlimited
abort  in  1  cancel current job
core_rst  out  NUM_CORES  per-core synchronous reset
core_start  out  NUM_CORES  one-cycle start pulse (drives core in_valid)
core_data/core_state/core_target/core_position  out  96/256/256/32  registered job fields, broadcast to all cores
core_nonce_base  out  32*NUM_CORES  slice i = nonce_base + i*STRIDE
core_done  in  NUM_CORES  core out_valid
core_nonce  in  32*NUM_CORES  core out_nonce_found
res_valid  out  1  result held until res_ready
res_ready  in  1  result consumer ready
res_found  out  1  1 = nonce found, 0 = timeout
res_nonce  out  32  winning nonce (0 if not found)
res_core  out  4  index of the winning core
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rstn low, async): state IDLE; core_rst all ones; core_start 0; res_valid/res_found 0; res_nonce/res_core 0; all broadcast and nonce-base registers 0; busy 0.
- IDLE: job_ready=1 and core_rst all ones. On job_valid&&job_ready, latch all job fields, compute core_nonce_base[i] = job_nonce_base + i*STRIDE (mod 2^32, wrap permitted), then go to RESET.
- RESET: core_rst stays all ones for RST_CYCLES cycles, then drops to zero when entering START.
- START: core_start all ones for exactly one cycle. Load timeout counter with job_timeout. Go to RUN.
- Timing: acceptance at cycle T gives core_start high at T+1+RST_CYCLES.
- RUN handling, in priority order:
  1. Any core_done bit high: the lowest set index wins. Register res_found=1, res_nonce=core_nonce[idx], res_core=idx. Go to REPORT.
  2. Else if job_timeout!=0 and counter==1: res_found=0, res_nonce=0, res_core=0. Go to REPORT. The RUN phase therefore lasts exactly job_timeout cycles.
  3. Else decrement the counter if job_timeout!=0.
  - A core_done that coincides with the last timeout cycle counts as found.
- REPORT: res_valid=1 starting the cycle after detection. Outputs hold steady until res_ready. The cycle res_valid&&res_ready is seen, go to IDLE (core_rst reasserts, res_valid drops).
- abort:
  - In RESET, START or RUN: go to IDLE next cycle, no result produced, core_rst reasserted.
  - Ignored in IDLE and REPORT.
  - Has priority over core_done in the same cycle.
- core_done is ignored outside RUN. A new job is never accepted while busy.
- res_core is zero-extended to 4 bits.

Test Plan:
- Found case: job nonce_base=0x0000_0010, timeout=1000; core 2 raises core_done with core_nonce=0x8000_1234 at RUN cycle 5 -> core_nonce_base = {0x10, 0x4000_0010, 0x8000_0010, 0xC000_0010}; core_start pulses at T+3; res_valid with found=1, nonce=0x8000_1234, core=2.
- Priority and handshake: cores 1 and 3 done in the same cycle -> res_core=1. Hold res_ready=0 for 10 cycles -> outputs stable; then res_ready=1 -> IDLE, job_ready=1 next cycle.
- Timeout: timeout=8, no done -> res_valid after 8 RUN cycles with found=0, nonce=0. Core done exactly on RUN cycle 8 -> found=1.
- Wrap-around: nonce_base=0xF000_0000 -> slices {0xF000_0000, 0x3000_0000, 0x7000_0000, 0xB000_0000}.
- Abort: abort during RESET, START and RUN (the RUN case together with a core_done) -> no res_valid, core_rst all ones, job_ready=1 one cycle later. A following job runs normally.
- Async reset mid-RUN: drop rstn between clock edges -> outputs go to reset values immediately; unlimited timeout (0) runs until done.
